// File: rtl/chan_merge_pkg.sv
// Shared limits and helpers for the chan_merge channel merger.
package chan_merge_pkg;

  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 16;
  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;
  localparam int DEPTH_MIN  = 2;
  localparam int DEPTH_MAX  = 32;

  // Width of the source-channel tag; never narrower than one bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/chan_merge_fifo.sv
// Single-channel flop-based FIFO with occupancy count and synchronous flush.
module chan_merge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem_reg[rd_ptr_reg];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

  // Storage needs no reset: contents are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/chan_merge.sv
// Merges NUM_CH buffered input channels into one stream via round-robin arbitration.
module chan_merge
  import chan_merge_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_CH-1:0]             in_valid,
  input  logic [NUM_CH*WIDTH-1:0]       in_data,
  output logic [NUM_CH-1:0]             in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic [ch_width(NUM_CH)-1:0]   out_ch,
  input  logic                          out_ready
);
  localparam int CW = ch_width(NUM_CH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] pop_vec;
  logic [WIDTH-1:0]  fifo_head [NUM_CH];
  logic [AW:0]       fifo_count [NUM_CH];

  logic              out_valid_reg;
  logic [WIDTH-1:0]  out_data_reg;
  logic [CW-1:0]     out_ch_reg;
  logic [CW-1:0]     last_reg;

  logic              loadable;
  logic              grant_valid;
  logic [CW-1:0]     grant_idx;
  logic              pop_en;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : gen_fifo
      chan_merge_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (in_valid[gi] && !fifo_full[gi]),
        .wr_data (in_data[gi*WIDTH +: WIDTH]),
        .pop     (pop_vec[gi]),
        .rd_data (fifo_head[gi]),
        .count   (fifo_count[gi]),
        .full    (fifo_full[gi]),
        .empty   (fifo_empty[gi])
      );

      // Ready looks only at the registered count, never at this cycle's pop.
      assign in_ready[gi] = (fifo_count[gi] < FULL_CNT);
      assign pop_vec[gi]  = pop_en && (grant_idx == CW'(gi));
    end
  endgenerate

  assign loadable = !out_valid_reg || out_ready;
  assign pop_en   = loadable && grant_valid && !flush;

  // Search starts one past the last granted channel and wraps around.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_reg) + i) % NUM_CH;
      if (!grant_valid && !fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = CW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      last_reg      <= CW'(NUM_CH - 1);
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
    end else if (loadable) begin
      out_valid_reg <= grant_valid;
      if (grant_valid) begin
        out_data_reg <= fifo_head[grant_idx];
        out_ch_reg   <= grant_idx;
        last_reg     <= grant_idx;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_chan_merge.sv
// Self-checking bench for chan_merge: vector table plus directed multi-cycle sequences.
module tb_chan_merge;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Per-channel expected words, oldest first.
  logic [7:0] exp_q [NUM_CH][$];

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_och;
    logic [3:0]  e_ir;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  chan_merge #(
    .NUM_CH (NUM_CH),
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic sb_clear();
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
  endtask

  function automatic int sb_size();
    int s;
    s = 0;
    for (int c = 0; c < NUM_CH; c++) s += exp_q[c].size();
    return s;
  endfunction

  // One clock: sample handshakes before the edge, update scoreboard at the edge.
  task automatic tick();
    logic        ov, orr, fl;
    logic [1:0]  och;
    logic [7:0]  od;
    logic [3:0]  iv, ir;
    logic [31:0] id;
    ov = out_valid; orr = out_ready; och = out_ch; od = out_data;
    iv = in_valid;  ir = in_ready;   id = in_data; fl = flush;
    @(posedge clk);
    if (fl || !rst_n) begin
      sb_clear();
    end else begin
      if (ov && orr) begin
        if (exp_q[och].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_word: got ch%0d data %0h, expected no word", och, od);
        end else begin
          check($sformatf("sb_word_ch%0d", och), 64'(od), 64'(exp_q[och].pop_front()));
        end
      end
      for (int c = 0; c < NUM_CH; c++)
        if (iv[c] && ir[c]) exp_q[c].push_back(id[c*8 +: 8]);
    end
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    sb_clear();
  endtask

  initial begin
    int drained;
    logic [7:0] w;

    // Reset values while rst_n is low
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_ch", 64'(out_ch), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single word on channel 2, then four-channel fairness after a fresh reset
    vecs[0]  = '{1'b0, 4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'hF};
    vecs[1]  = '{1'b0, 4'b0000, 32'h0,         1'b1, 1'b1, 8'hA5, 2'd2, 4'hF};
    vecs[2]  = '{1'b0, 4'b0000, 32'h0,         1'b1, 1'b0, 8'h00, 2'd0, 4'hF};
    vecs[3]  = '{1'b1, 4'b1111, 32'h3020_1000, 1'b0, 1'b0, 8'h00, 2'd0, 4'hF};
    vecs[4]  = '{1'b0, 4'b1111, 32'h3121_1101, 1'b0, 1'b1, 8'h00, 2'd0, 4'hF};
    vecs[5]  = '{1'b0, 4'b0000, 32'h0,         1'b1, 1'b1, 8'h10, 2'd1, 4'hF};
    vecs[6]  = '{1'b0, 4'b0000, 32'h0,         1'b1, 1'b1, 8'h20, 2'd2, 4'hF};
    vecs[7]  = '{1'b0, 4'b0000, 32'h0,         1'b1, 1'b1, 8'h30, 2'd3, 4'hF};
    vecs[8]  = '{1'b0, 4'b0000, 32'h0,         1'b1, 1'b1, 8'h01, 2'd0, 4'hF};
    vecs[9]  = '{1'b0, 4'b0000, 32'h0,         1'b1, 1'b1, 8'h11, 2'd1, 4'hF};
    vecs[10] = '{1'b0, 4'b0000, 32'h0,         1'b1, 1'b1, 8'h21, 2'd2, 4'hF};
    vecs[11] = '{1'b0, 4'b0000, 32'h0,         1'b1, 1'b1, 8'h31, 2'd3, 4'hF};
    vecs[12] = '{1'b0, 4'b0000, 32'h0,         1'b1, 1'b0, 8'h00, 2'd0, 4'hF};

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) pulse_reset();
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      tick();
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].e_od));
        check($sformatf("vec%0d_out_ch", i), 64'(out_ch), 64'(vecs[i].e_och));
      end
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
    end

    // Backpressure: six pushes on channel 1, only five fit (one in output, four buffered)
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      in_data = 32'(8'h50 + 8'(i)) << 8;
      tick();
      check($sformatf("bp_in_ready1_%0d", i), 64'(in_ready[1]), (i < 4) ? 64'(1) : 64'(0));
      if (i > 0) check($sformatf("bp_hold_%0d", i), 64'(out_data), 64'h50);
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("bp_drain_%0d", i), 64'({out_valid, out_data}), 64'({1'b1, 8'h50 + 8'(i)}));
    end
    tick();
    check("bp_drain_end", 64'(out_valid), 64'(0));

    // Channel 3 held at count 2 while pushing and popping every cycle
    out_ready = 1'b0;
    in_valid  = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      in_data = {8'(8'hC0 + 8'(i)), 24'h0};
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w = 8'($urandom_range(0, 255));
      in_data = {w, 24'h0};
      tick();
    end
    out_ready = 1'b0;
    in_data = {8'hE0, 24'h0};
    tick();
    check("pp_ready_after_3", 64'(in_ready[3]), 64'(1));
    in_data = {8'hE1, 24'h0};
    tick();
    check("pp_ready_after_4", 64'(in_ready[3]), 64'(0));
    in_valid  = '0;
    out_ready = 1'b1;
    drained   = 0;
    for (int k = 0; k < 20 && out_valid; k++) begin
      tick();
      drained++;
    end
    check("pp_drained", 64'(drained), 64'(5));

    // Flush with three channels partly full and a held output word
    out_ready = 1'b0;
    in_valid  = 4'b0111;
    in_data   = 32'h00_3A_2A_1A;
    tick();
    in_data   = 32'h00_3B_2B_1B;
    tick();
    check("fl_pre_out_valid", 64'(out_valid), 64'(1));
    flush   = 1'b1;
    in_data = 32'h00_3C_2C_1C;
    tick();
    flush = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'(0));
    check("fl_in_ready", 64'(in_ready), 64'hF);
    in_valid  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_no_stale_%0d", i), 64'(out_valid), 64'(0));
    end
    in_valid = 4'b0010;
    in_data  = 32'h0000_7700;
    tick();
    in_valid = '0;
    tick();
    check("fl_after_word", 64'({out_valid, out_ch, out_data}), 64'({1'b1, 2'd1, 8'h77}));
    tick();

    // Asynchronous reset between edges in the middle of a burst
    in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      tick();
    end
    #3 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'(0));
    check("ar_out_data", 64'(out_data), 64'(0));
    check("ar_out_ch", 64'(out_ch), 64'(0));
    check("ar_in_ready", 64'(in_ready), 64'hF);
    sb_clear();
    in_data = 32'h9080_7060;
    #2 rst_n = 1'b1;
    tick();
    in_valid = '0;
    tick();
    check("ar_first_grant", 64'({out_valid, out_ch, out_data}), 64'({1'b1, 2'd0, 8'h60}));
    for (int k = 0; k < 20 && out_valid; k++) tick();
    check("ar_drain_done", 64'(out_valid), 64'(0));
    check("sb_all_consumed", 64'(sb_size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
